rx_unit: RTL and testbench

UART receive unit, the serial-to-parallel counterpart of the UART transmit unit. Oversamples the asynchronous `rxd` line on an external baud-multiple tick, detects and validates the start bit, deserialises 8 data bits LSB first, and checks the stop bit. The assembled byte and its status flags go to the UART register/bus interface, which acknowledges each byte with `clr_rs`.

---
 rtl/rx_unit.sv | 94 +++++++++
 tb/tb_rx_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_unit.sv
// rx_unit: UART receiver, oversampled start/data/stop deserialiser with rs/fe/oe status
module rx_unit #(
  parameter int OVS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       en_rx,
  input  logic       clr_rs,
  output logic [7:0] d_out,
  output logic       rs,
  output logic       fe,
  output logic       oe
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF = CW'(OVS / 2 - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  state_t st_q, st_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] sync_q;
  logic [7:0] sh_q, sh_d, d_out_q, d_out_d;
  logic rs_q, rs_d, fe_q, fe_d, oe_q, oe_d, done, rxs;
  assign rxs = sync_q[1];
  assign d_out = d_out_q;
  assign rs = rs_q;
  assign fe = fe_q;
  assign oe = oe_q;
  always_comb begin
    st_d = st_q;
    tick_d = tick_q;
    bit_d = bit_q;
    sh_d = sh_q;
    done = 1'b0;
    if (en_rx) begin
      case (st_q)
        IDLE: if (!rxs) begin
          st_d = START;
          tick_d = '0;
        end
        START: if (tick_q == HALF) begin
          st_d = rxs ? IDLE : DATA;
          tick_d = '0;
          bit_d = '0;
        end else tick_d = tick_q + 1'b1;
        DATA: begin
          tick_d = tick_q + 1'b1;
          if (&tick_q) begin
            sh_d = {rxs, sh_q[7:1]};
            bit_d = bit_q + 1'b1;
            st_d = (bit_q == 3'd7) ? STOP : DATA;
          end
        end
        STOP: begin
          tick_d = tick_q + 1'b1;
          if (&tick_q) begin
            done = 1'b1;
            st_d = rxs ? IDLE : WAITHI;
          end
        end
        WAITHI: st_d = rxs ? IDLE : WAITHI;
        default: st_d = IDLE;
      endcase
    end
    // a completion beats a coincident clear; overrun only when the old byte was unread
    rs_d = done | (rs_q & ~clr_rs);
    oe_d = done ? (~clr_rs & (rs_q | oe_q)) : (oe_q & ~clr_rs);
    fe_d = done ? ~rxs : fe_q;
    d_out_d = done ? sh_q : d_out_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      sync_q <= 2'b11;
      sh_q <= '0;
      d_out_q <= '0;
      rs_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      st_q <= st_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      sync_q <= {sync_q[0], rxd};
      sh_q <= sh_d;
      d_out_q <= d_out_d;
      rs_q <= rs_d;
      fe_q <= fe_d;
      oe_q <= oe_d;
    end
  end
endmodule

// File: tb/tb_rx_unit.sv
// tb_rx_unit: frame-level UART receive model compared every cycle, plus directed literal checks
module tb_rx_unit;
  localparam int OVS = 8;
  localparam int H = OVS / 2;
  logic clk, rst, rxd, en_rx, clr_rs;
  logic [7:0] d_out;
  logic rs, fe, oe;
  logic [1:0] ph = '0;
  int total = 0, bad = 0, rises = 0;
  logic prev_rs = 1'b0, rand_clr = 1'b0, found;
  int mode = 0, n = 0, k;
  logic s1 = 1'b1, s2 = 1'b1, done;
  logic [7:0] sb = '0, m_d = '0;
  logic m_rs = 1'b0, m_fe = 1'b0, m_oe = 1'b0;

  rx_unit #(.OVS(OVS)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .en_rx(en_rx), .clr_rs(clr_rs),
    .d_out(d_out), .rs(rs), .fe(fe), .oe(oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ph <= ph + 2'd1;
  assign en_rx = (ph == 2'd3);

  // frame model: ticks counted from the start-edge detection tick
  always @(posedge clk) begin
    done = 1'b0;
    if (rst) begin
      mode = 0; n = 0; m_d = '0; m_rs = 1'b0; m_fe = 1'b0; m_oe = 1'b0; s1 = 1'b1; s2 = 1'b1;
    end else begin
      if (en_rx) begin
        if (mode == 0) begin
          if (!s2) begin mode = 1; n = 0; end
        end else if (mode == 1) begin
          n = n + 1;
          if (n == H && s2) mode = 0;
          else if (n > H && (n - H) % OVS == 0) begin
            k = (n - H) / OVS - 1;
            if (k < 8) sb[k] = s2;
            else begin
              done = 1'b1;
              m_oe = clr_rs ? 1'b0 : (m_rs ? 1'b1 : m_oe);
              m_rs = 1'b1;
              m_d = sb;
              m_fe = !s2;
              mode = s2 ? 0 : 2;
            end
          end
        end else if (s2) mode = 0;
      end
      if (clr_rs && !done) begin m_rs = 1'b0; m_oe = 1'b0; end
      s2 = s1;
      s1 = rxd;
    end
  end

  task automatic cyc(input int c);
    repeat (c) begin
      @(negedge clk);
      total++;
      if ({d_out, rs, fe, oe} !== {m_d, m_rs, m_fe, m_oe}) begin
        bad++;
        if (bad < 30)
          $display("FAIL per_cycle t=%0t dut d=%h rs=%b fe=%b oe=%b model d=%h rs=%b fe=%b oe=%b",
                   $time, d_out, rs, fe, oe, m_d, m_rs, m_fe, m_oe);
      end
      if (rs && !prev_rs) rises++;
      prev_rs = rs;
      if (rand_clr) clr_rs = ($urandom_range(0, 63) == 0);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stopb, input int p, input int abort_bit);
    rxd = 1'b0;
    cyc(p);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      if (i == abort_bit) begin
        cyc(p / 2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(p - p / 2 - 1);
      end else cyc(p);
    end
    rxd = stopb;
    cyc(p);
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rs = 1'b1;
    cyc(1);
    clr_rs = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; rxd = 1'b1; clr_rs = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("reset_d_out", d_out, 8'h00);
    chk("reset_flags", {rs, fe, oe}, 3'b000);
    rises = 0;
    cyc(400);
    chk("idle_no_rs", rises, 0);

    send_frame(8'h55, 1'b1, 32, -1);
    chk("b55_d_out", d_out, 8'h55);
    chk("b55_flags", {rs, fe, oe}, 3'b100);
    pulse_clr();
    chk("b55_cleared", rs, 1'b0);
    send_frame(8'hA3, 1'b1, 32, -1);
    chk("bA3_d_out", d_out, 8'hA3);
    chk("bA3_flags", {rs, fe, oe}, 3'b100);
    pulse_clr();

    rises = 0;
    rxd = 1'b0;
    cyc(8);
    rxd = 1'b1;
    cyc(40);
    chk("glitch_no_rs", {rises[7:0], rs}, 9'd0);
    send_frame(8'h0F, 1'b1, 32, -1);
    chk("b0F_d_out", d_out, 8'h0F);
    chk("b0F_rs", rs, 1'b1);
    pulse_clr();

    rises = 0;
    send_frame(8'hA5, 1'b0, 32, -1);
    rxd = 1'b0;
    cyc(20 * 32);
    chk("break_d_out", d_out, 8'hA5);
    chk("break_flags", {rs, fe, oe}, 3'b110);
    chk("break_one_byte", rises, 1);
    rxd = 1'b1;
    cyc(64);
    pulse_clr();
    chk("fe_kept_after_clr", fe, 1'b1);
    send_frame(8'h3C, 1'b1, 32, -1);
    chk("b3C_d_out", d_out, 8'h3C);
    chk("b3C_fe", fe, 1'b0);
    pulse_clr();

    send_frame(8'h11, 1'b1, 32, -1);
    send_frame(8'h22, 1'b1, 32, -1);
    chk("overrun_d_out", d_out, 8'h22);
    chk("overrun_flags", {rs, oe}, 2'b11);
    pulse_clr();
    chk("overrun_cleared", {rs, oe}, 2'b00);
    send_frame(8'h44, 1'b1, 32, -1);
    chk("b44_rs", {rs, oe}, 2'b10);
    found = 1'b0;
    fork
      send_frame(8'h33, 1'b1, 32, -1);
      for (int i = 0; i < 700 && !found; i++) begin
        @(negedge clk);
        if (mode == 1 && n == H + 9 * OVS - 1 && en_rx) begin
          clr_rs = 1'b1;
          @(negedge clk);
          clr_rs = 1'b0;
          found = 1'b1;
        end
      end
    join
    chk("coincident_found", found, 1'b1);
    chk("coincident_d_out", d_out, 8'h33);
    chk("coincident_flags", {rs, oe}, 2'b10);
    pulse_clr();

    send_frame(8'hFF, 1'b1, 32, 4);
    cyc(32);
    chk("abort_no_rs", rs, 1'b0);
    send_frame(8'h81, 1'b1, 32, -1);
    chk("b81_d_out", d_out, 8'h81);
    chk("b81_rs", rs, 1'b1);
    pulse_clr();

    rand_clr = 1'b1;
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        rxd = 1'b0;
        cyc($urandom_range(1, 12));
        rxd = 1'b1;
        cyc(30);
      end
      send_frame(8'($urandom), ($urandom_range(0, 7) != 0), $urandom_range(30, 34), -1);
      cyc($urandom_range(0, 40));
    end
    rand_clr = 1'b0;
    clr_rs = 1'b0;
    cyc(400);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
